// File: rtl/cim_mem_arbiter.sv
// Fixed-priority arbiter from the five CiM memory-access sources onto the single-port temp-result SRAM.
// Optional access/conflict counters are enabled with `define CIM_MEM_ARB_STATS_EN.
module cim_mem_arbiter #(
  parameter int N_SRC  = 5,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          read_req_src,
  input  logic [N_SRC-1:0]          write_req_src,
  input  logic [N_SRC*ADDR_W-1:0]   addr_table,
  input  logic [N_SRC*DATA_W-1:0]   write_data,
  output logic [N_SRC-1:0]          grant,
  output logic                      sram_en,
  output logic                      sram_we,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  input  logic [DATA_W-1:0]         sram_rdata,
  output logic [DATA_W-1:0]         rd_data,
  output logic [N_SRC-1:0]          rd_valid,
  output logic                      conflict,
  output logic                      conflict_sticky,
  input  logic                      clear_err,
  output logic                      busy
`ifdef CIM_MEM_ARB_STATS_EN
  ,
  output logic [15:0]               stat_reads,
  output logic [15:0]               stat_writes,
  output logic [15:0]               stat_conflicts
`endif
);

  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  // Handshake: a source raises its request and holds it until grant (same
  // cycle, combinational) shows it was accepted; losers simply retry.
  logic [N_SRC-1:0]  req;
  logic [SRC_W-1:0]  win_idx;
  logic              win_any;
  logic              win_we;
  logic              win_rd;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              conflict_c;

  logic [RD_LAT:0]   tag_v;
  logic [SRC_W-1:0]  tag_src [RD_LAT+1];

  always_comb begin
    req     = read_req_src | write_req_src;
    win_idx = '0;
    win_any = 1'b0;
    // Scan downwards so the lowest requesting index is the last one kept.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = SRC_W'(i);
        win_any = 1'b1;
      end
    end
    grant = '0;
    if (win_any) grant[win_idx] = 1'b1;
    win_we     = win_any & write_req_src[win_idx];
    win_rd     = win_any & ~win_we;
    win_addr   = addr_table[win_idx*ADDR_W +: ADDR_W];
    win_wdata  = write_data[win_idx*DATA_W +: DATA_W];
    conflict_c = (|(req & (req - N_SRC'(1)))) | (|(read_req_src & write_req_src));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_en         <= 1'b0;
      sram_we         <= 1'b0;
      sram_addr       <= '0;
      sram_wdata      <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      tag_v           <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_src[k] <= '0;
      rd_data         <= '0;
      rd_valid        <= '0;
    end else begin
      sram_en <= win_any;
      sram_we <= win_we;
      if (win_any) begin
        sram_addr  <= win_addr;
        sram_wdata <= win_wdata;
      end
      conflict <= conflict_c;
      if (conflict_c)     conflict_sticky <= 1'b1;
      else if (clear_err) conflict_sticky <= 1'b0;
      // Stage RD_LAT lines up with the cycle in which sram_rdata is valid.
      tag_v      <= {tag_v[RD_LAT-1:0], win_rd};
      tag_src[0] <= win_idx;
      for (int k = 1; k <= RD_LAT; k++) tag_src[k] <= tag_src[k-1];
      rd_valid <= '0;
      if (tag_v[RD_LAT]) begin
        rd_valid[tag_src[RD_LAT]] <= 1'b1;
        rd_data                   <= sram_rdata;
      end
    end
  end

  assign busy = |tag_v;

`ifdef CIM_MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads     <= '0;
      stat_writes    <= '0;
      stat_conflicts <= '0;
    end else if (clear_err) begin
      stat_reads     <= '0;
      stat_writes    <= '0;
      stat_conflicts <= '0;
    end else begin
      if (win_rd && stat_reads != 16'hFFFF)       stat_reads     <= stat_reads + 16'd1;
      if (win_we && stat_writes != 16'hFFFF)      stat_writes    <= stat_writes + 16'd1;
      if (conflict && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Directed bench for cim_mem_arbiter: one instance at RD_LAT=1, one at RD_LAT=2,
// both fed the same requests and backed by a behavioural SRAM model.
module tb_cim_mem_arbiter;

  localparam int N_SRC  = 5;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  logic                    clk;
  logic                    rst_n;
  logic [N_SRC-1:0]        read_req_src;
  logic [N_SRC-1:0]        write_req_src;
  logic [N_SRC*ADDR_W-1:0] addr_table;
  logic [N_SRC*DATA_W-1:0] write_data;
  logic                    clear_err;

  logic [N_SRC-1:0]  grant, grant_b;
  logic              sram_en, sram_en_b, sram_we, sram_we_b;
  logic [ADDR_W-1:0] sram_addr, sram_addr_b;
  logic [DATA_W-1:0] sram_wdata, sram_wdata_b, sram_rdata, sram_rdata_b;
  logic [DATA_W-1:0] rd_data, rd_data_b;
  logic [N_SRC-1:0]  rd_valid, rd_valid_b;
  logic              conflict, conflict_b, conflict_sticky, conflict_sticky_b;
  logic              busy, busy_b;
`ifdef CIM_MEM_ARB_STATS_EN
  logic [15:0] stat_reads, stat_writes, stat_conflicts;
  logic [15:0] stat_reads_b, stat_writes_b, stat_conflicts_b;
`endif

  int checks = 0;
  int errors = 0;

  cim_mem_arbiter #(.N_SRC(N_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .read_req_src(read_req_src), .write_req_src(write_req_src),
    .addr_table(addr_table), .write_data(write_data), .grant(grant), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .conflict(conflict), .conflict_sticky(conflict_sticky),
    .clear_err(clear_err), .busy(busy)
`ifdef CIM_MEM_ARB_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_conflicts(stat_conflicts)
`endif
  );

  cim_mem_arbiter #(.N_SRC(N_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .read_req_src(read_req_src), .write_req_src(write_req_src),
    .addr_table(addr_table), .write_data(write_data), .grant(grant_b), .sram_en(sram_en_b),
    .sram_we(sram_we_b), .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .conflict(conflict_b), .conflict_sticky(conflict_sticky_b),
    .clear_err(clear_err), .busy(busy_b)
`ifdef CIM_MEM_ARB_STATS_EN
    , .stat_reads(stat_reads_b), .stat_writes(stat_writes_b), .stat_conflicts(stat_conflicts_b)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: storage written by the RD_LAT=1 instance; read ports at latency 1 and 2.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] rd_a, rd_b0, rd_b1;
  always @(posedge clk) begin
    if (sram_en && sram_we)    mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_we)   rd_a  <= mem[sram_addr];
    if (sram_en_b && !sram_we_b) rd_b0 <= mem[sram_addr_b];
    rd_b1 <= rd_b0;
  end
  assign sram_rdata   = rd_a;
  assign sram_rdata_b = rd_b1;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    read_req_src  = '0;
    write_req_src = '0;
    addr_table    = '0;
    write_data    = '0;
  endtask

  task automatic set_req(input int src, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    read_req_src[src]                 = rd;
    write_req_src[src]                = wr;
    addr_table[src*ADDR_W +: ADDR_W]  = a;
    write_data[src*DATA_W +: DATA_W]  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_err = 1'b0;
    clr_req();
    #3;
    checks++;
    if ({grant, sram_en, sram_we, sram_addr, sram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got grant=%b en=%b we=%b addr=%h wdata=%h, need all 0",
               grant, sram_en, sram_we, sram_addr, sram_wdata);
    end
    checks++;
    if ({rd_data, rd_valid, conflict, conflict_sticky, busy} !== '0) begin
      errors++;
      $display("FAIL reset_rd: got rd_data=%h rd_valid=%b conflict=%b sticky=%b busy=%b, need all 0",
               rd_data, rd_valid, conflict, conflict_sticky, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    clr_req();
    set_req(3, 1'b0, 1'b1, 10'h1A3, 16'h00AB);
    #1;
    checks++;
    if (grant !== 5'b01000) begin
      errors++; $display("FAIL t1_wr_grant: got %b need 01000", grant);
    end
    tick();
    checks++;
    if ({sram_en, sram_we, sram_addr, sram_wdata} !== {1'b1, 1'b1, 10'h1A3, 16'h00AB}) begin
      errors++;
      $display("FAIL t1_wr_issue: got en=%b we=%b addr=%h wdata=%h need 1 1 1a3 00ab",
               sram_en, sram_we, sram_addr, sram_wdata);
    end
    clr_req();
    set_req(3, 1'b1, 1'b0, 10'h1A3, 16'h0000);
    #1;
    checks++;
    if (grant !== 5'b01000) begin
      errors++; $display("FAIL t1_rd_grant: got %b need 01000", grant);
    end
    tick();
    clr_req();
    checks++;
    if ({sram_en, sram_we, sram_addr} !== {1'b1, 1'b0, 10'h1A3}) begin
      errors++;
      $display("FAIL t1_rd_issue: got en=%b we=%b addr=%h need 1 0 1a3", sram_en, sram_we, sram_addr);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (rd_valid !== ((c == 3) ? 5'b01000 : 5'b00000)) begin
        errors++; $display("FAIL t1_rd_valid_c%0d: got %b need %b", c, rd_valid,
                           (c == 3) ? 5'b01000 : 5'b00000);
      end
      if (c >= 3) begin
        checks++;
        if (rd_data !== 16'h00AB) begin
          errors++; $display("FAIL t1_rd_data_c%0d: got %h need 00ab", c, rd_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_conflict_priority();
    clr_req();
    set_req(2, 1'b1, 1'b0, 10'h010, 16'h0);
    set_req(4, 1'b1, 1'b0, 10'h020, 16'h0);
    #1;
    checks++;
    if (grant !== 5'b00100) begin
      errors++; $display("FAIL t2_grant0: got %b need 00100", grant);
    end
    tick();
    clr_req();
    set_req(4, 1'b1, 1'b0, 10'h020, 16'h0);
    #1;
    checks++;
    if ({grant, conflict, conflict_sticky, sram_addr} !== {5'b10000, 1'b1, 1'b1, 10'h010}) begin
      errors++;
      $display("FAIL t2_cycle1: got grant=%b conflict=%b sticky=%b addr=%h need 10000 1 1 010",
               grant, conflict, conflict_sticky, sram_addr);
    end
    tick();
    clr_req();
    checks++;
    if ({conflict, conflict_sticky, sram_addr, rd_valid} !== {1'b0, 1'b1, 10'h020, 5'b00000}) begin
      errors++;
      $display("FAIL t2_cycle2: got conflict=%b sticky=%b addr=%h rd_valid=%b need 0 1 020 00000",
               conflict, conflict_sticky, sram_addr, rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 5'b00100) begin
      errors++; $display("FAIL t2_rv_mac: got %b need 00100", rd_valid);
    end
    tick();
    checks++;
    if ({rd_valid, conflict_sticky} !== {5'b10000, 1'b1}) begin
      errors++; $display("FAIL t2_rv_softmax: got rd_valid=%b sticky=%b need 10000 1", rd_valid, conflict_sticky);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if ({conflict_sticky, conflict, rd_valid} !== '0) begin
      errors++; $display("FAIL t2_clear: got sticky=%b conflict=%b rd_valid=%b need 0 0 0",
                         conflict_sticky, conflict, rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      clr_req();
      set_req(0, 1'b0, 1'b1, ADDR_W'(i), DATA_W'(16'h3C00 + i));
      tick();
    end
    clr_req();
    tick();
    tick();
    for (int c = 0; c <= 8; c++) begin
      logic [N_SRC-1:0] exp_rv;
      logic             exp_busy;
      clr_req();
      if (c < 4) set_req(c, 1'b1, 1'b0, ADDR_W'(c), 16'h0);
      exp_rv   = (c >= 4 && c <= 7) ? N_SRC'(1 << (c - 4)) : '0;
      exp_busy = (c >= 1 && c <= 6);
      checks++;
      if ({rd_valid_b, busy_b} !== {exp_rv, exp_busy}) begin
        errors++;
        $display("FAIL t3_b2b_c%0d: got rd_valid=%b busy=%b need %b %b", c, rd_valid_b, busy_b, exp_rv, exp_busy);
      end
      if (exp_rv != '0) begin
        checks++;
        if (rd_data_b !== DATA_W'(16'h3C00 + c - 4)) begin
          errors++; $display("FAIL t3_data_c%0d: got %h need %h", c, rd_data_b, DATA_W'(16'h3C00 + c - 4));
        end
      end
      tick();
    end
  endtask

  task automatic test_rw_same_source();
    clr_req();
    set_req(2, 1'b1, 1'b1, 10'h044, 16'h1234);
    #1;
    checks++;
    if (grant !== 5'b00100) begin
      errors++; $display("FAIL t4_grant: got %b need 00100", grant);
    end
    tick();
    clr_req();
    checks++;
    if ({sram_en, sram_we, sram_addr, sram_wdata, conflict, busy} !==
        {1'b1, 1'b1, 10'h044, 16'h1234, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL t4_issue: got en=%b we=%b addr=%h wdata=%h conflict=%b busy=%b need 1 1 044 1234 1 0",
               sram_en, sram_we, sram_addr, sram_wdata, conflict, busy);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (rd_valid !== 5'b00000) begin
        errors++; $display("FAIL t4_no_rv_c%0d: got %b need 00000", c, rd_valid);
      end
      tick();
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  task automatic test_reset_inflight();
    clr_req();
    set_req(4, 1'b1, 1'b0, 10'h1A3, 16'h0);
    tick();
    clr_req();
    checks++;
    if ({sram_en, busy} !== 2'b11) begin
      errors++; $display("FAIL t5_pre: got en=%b busy=%b need 1 1", sram_en, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, sram_en, sram_we, sram_addr, sram_wdata, rd_data, rd_valid,
         conflict, conflict_sticky, busy} !== '0) begin
      errors++;
      $display("FAIL t5_async_rst: got en=%b we=%b addr=%h rd_valid=%b rd_data=%h busy=%b need all 0",
               sram_en, sram_we, sram_addr, rd_valid, rd_data, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({rd_valid, busy} !== '0) begin
        errors++; $display("FAIL t5_post_c%0d: got rd_valid=%b busy=%b need 0 0", c, rd_valid, busy);
      end
    end
  endtask

`ifdef CIM_MEM_ARB_STATS_EN
  task automatic test_stats();
    clr_req();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clr_req();
      set_req(i, 1'b1, 1'b0, ADDR_W'(i), 16'h0);
      tick();
    end
    clr_req();
    set_req(1, 1'b0, 1'b1, 10'h005, 16'h0007);
    tick();
    clr_req();
    set_req(0, 1'b0, 1'b1, 10'h006, 16'h0008);
    set_req(2, 1'b1, 1'b0, 10'h007, 16'h0);
    tick();
    clr_req();
    tick();
    tick();
    checks++;
    if ({stat_reads, stat_writes, stat_conflicts} !== {16'd3, 16'd2, 16'd1}) begin
      errors++;
      $display("FAIL t6_stats: got r=%0d w=%0d c=%0d need 3 2 1", stat_reads, stat_writes, stat_conflicts);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if ({stat_reads, stat_writes, stat_conflicts} !== '0) begin
      errors++;
      $display("FAIL t6_clear: got r=%0d w=%0d c=%0d need 0 0 0", stat_reads, stat_writes, stat_conflicts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_conflict_priority();
    test_back_to_back();
    test_rw_same_source();
    test_reset_inflight();
`ifdef CIM_MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
